// File: rtl/button_pio_debounced.sv
// rtl/button_pio_debounced.sv - multi-bit push-button PIO with sync, debounce, edge capture and irq
module button_pio_debounced #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1,
    parameter int IDLE_LEVEL      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [WIDTH-1:0] IDLE    = (IDLE_LEVEL != 0) ? '1 : '0;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_event;
    logic [WIDTH-1:0] edge_clr;
    logic             wr;
    logic             wdata_unused;

    assign wr           = chipselect & ~write_n;
    assign edge_clr     = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign wdata_unused = ^writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive samples differ from stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= IDLE;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_event = stable & ~stable_d;
            1:       edge_event = ~stable & stable_d;
            default: edge_event = stable ^ stable_d;
        endcase
    end

    // Set has priority over a write-1-to-clear landing on the same bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_d <= IDLE;
            edge_cap <= '0;
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            stable_d <= stable;
            edge_cap <= (edge_cap & ~edge_clr) | edge_event;
            if (wr && address == 2'd1) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            irq <= |(edge_cap & irq_mask);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            case (address)
                2'd0:    readdata <= 32'(stable);
                2'd1:    readdata <= 32'(irq_mask);
                2'd2:    readdata <= 32'(sync2);
                default: readdata <= 32'(edge_cap);
            endcase
        end
    end

endmodule
